// File: rtl/nes_controller_responder_pkg.sv
// Shared constants for the NES/SNES controller responder: frame sizes, button indices, FSM encoding.
// Pure definitions; no timing or flow-control behaviour.
package nes_pkg;

  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;

  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Active-low snapshot; every bit above the mode's button count reads as released.
  function automatic logic [15:0] load_word(input logic [11:0] btn, input logic snes);
    load_word = 16'hFFFF;
    if (snes) load_word[11:0] = ~btn;
    else      load_word[7:0]  = ~btn[7:0];
  endfunction

endpackage

// File: rtl/nes_controller_responder_pin_sync_edge.sv
// Multi-stage synchronizer for an asynchronous host pin, plus rise/fall detection on the synced level.
// Latency: SYNC_STAGES cycles to level/rise/fall; no backpressure.
module pin_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/nes_controller_responder.sv
// Gamepad-side 4021 emulation: snapshots buttons on latch, shifts them out active-low on host clock rises.
// Latency: pin edge to nes_data is SYNC_STAGES+1 cycles; the host paces everything, no backpressure.
module nes_controller_responder
  import nes_pkg::*;
#(
  parameter int          SNES_MODE      = 0,
  parameter int          SYNC_STAGES    = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] buttons,
  input  logic        nes_latch,
  input  logic        nes_clk,
  output logic        nes_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int         N      = (SNES_MODE != 0) ? SNES_BITS : NES_BITS;
  localparam logic [4:0] N_LAST = 5'(N);
  localparam logic       SNES   = (SNES_MODE != 0);

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_rise, clk_level_unused, clk_fall_unused;

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (nes_latch),
    .level (latch_lvl),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (nes_clk),
    .level (clk_level_unused),
    .rise  (clk_rise),
    .fall  (clk_fall_unused)
  );

  // Register is always 16 wide; in NES mode the upper byte stays all-ones and
  // feeds released bits into position 7, so one shift path serves both modes.
  state_t      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d, cnt_inc;
  logic [15:0] tmo_q, tmo_d, tmo_inc;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    cnt_inc = cnt_q + 5'd1;
    tmo_inc = tmo_q + 16'd1;

    // A latch rise pre-empts everything, including a coincident clock rise.
    if (latch_rise) begin
      state_d = ST_LOAD;
      sr_d    = load_word(buttons, SNES);
      cnt_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: sr_d = '1;
        ST_LOAD: begin
          sr_d  = load_word(buttons, SNES);
          cnt_d = '0;
          tmo_d = '0;
          if (latch_fall) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (clk_rise && !latch_lvl) begin
            sr_d  = {1'b1, sr_q[15:1]};
            cnt_d = cnt_inc;
            tmo_d = '0;
            if (cnt_inc == N_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else if (tmo_inc == TIMEOUT_CYCLES) begin
            state_d = ST_IDLE;
            sr_d    = '1;
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_inc;
          end
        end
        ST_DONE: sr_d = '1;
        default: begin
          state_d = ST_IDLE;
          sr_d    = '1;
        end
      endcase
    end

    busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '1;
      cnt_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign nes_data   = sr_q[0];
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Bench: an NES responder (short timeout) and an SNES responder share the host pins; each is checked
// against a frame model: inverted button list, then released (1) bits forever.
module tb_nes_controller_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] buttons = '0;
  logic        nes_latch = 1'b0;
  logic        nes_clk = 1'b0;
  logic        n_data, n_busy, n_fd;
  logic        s_data, s_busy, s_fd;

  int compared = 0;
  int mismatched = 0;
  int fd_n_cnt = 0;
  int fd_s_cnt = 0;

  always #5 clk = ~clk;

  nes_controller_responder #(.SNES_MODE(0), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16'd100)) dut_nes (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .nes_latch(nes_latch), .nes_clk(nes_clk),
    .nes_data(n_data), .busy(n_busy), .frame_done(n_fd)
  );

  nes_controller_responder #(.SNES_MODE(1), .SYNC_STAGES(2)) dut_snes (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .nes_latch(nes_latch), .nes_clk(nes_clk),
    .nes_data(s_data), .busy(s_busy), .frame_done(s_fd)
  );

  // Bit k of a frame as the host sees it after k clock rises.
  function automatic logic exp_bit(input logic [11:0] b, input int nb, input int k);
    if (k < nb) return ~b[k];
    return 1'b1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (n_fd === 1'b1) begin
      fd_n_cnt++;
      compared++;
      if (n_data !== 1'b1) begin
        mismatched++;
        $display("FAIL nes_fd_data: nes_data=%b at frame_done, expected 1", n_data);
      end
    end
    if (s_fd === 1'b1) begin
      fd_s_cnt++;
      compared++;
      if (s_data !== 1'b1) begin
        mismatched++;
        $display("FAIL snes_fd_data: nes_data=%b at frame_done, expected 1", s_data);
      end
    end
  end

  // Latch with optional clock pulses while latched, then nclk clocks; every bit compared to the model.
  task automatic run_frame(input logic [11:0] b, input int pre, input int nclk, input int h);
    int fdn0, fds0;
    fdn0 = fd_n_cnt;
    fds0 = fd_s_cnt;
    buttons = b;
    nes_latch = 1'b1;
    cyc(h);
    for (int i = 0; i < pre; i++) begin
      nes_clk = 1'b1; cyc(h);
      nes_clk = 1'b0; cyc(h);
    end
    compared += 4;
    if (n_data !== ~b[0]) begin mismatched++; $display("FAIL nes_latch_track: got %b want %b", n_data, ~b[0]); end
    if (s_data !== ~b[0]) begin mismatched++; $display("FAIL snes_latch_track: got %b want %b", s_data, ~b[0]); end
    if (n_busy !== 1'b1) begin mismatched++; $display("FAIL nes_busy_load: got %b want 1", n_busy); end
    if (s_busy !== 1'b1) begin mismatched++; $display("FAIL snes_busy_load: got %b want 1", s_busy); end
    nes_latch = 1'b0;
    cyc(h);
    buttons = 12'($urandom);
    for (int k = 0; k <= nclk; k++) begin
      if (k > 0) begin nes_clk = 1'b1; cyc(h); end
      compared += 4;
      if (n_data !== exp_bit(b, 8, k)) begin
        mismatched++; $display("FAIL nes_bit%0d: btn=%h got %b want %b", k, b, n_data, exp_bit(b, 8, k));
      end
      if (s_data !== exp_bit(b, 12, k)) begin
        mismatched++; $display("FAIL snes_bit%0d: btn=%h got %b want %b", k, b, s_data, exp_bit(b, 12, k));
      end
      if (n_busy !== (k < 8)) begin
        mismatched++; $display("FAIL nes_busy_bit%0d: got %b want %b", k, n_busy, (k < 8));
      end
      if (s_busy !== (k < 16)) begin
        mismatched++; $display("FAIL snes_busy_bit%0d: got %b want %b", k, s_busy, (k < 16));
      end
      if (k > 0) begin nes_clk = 1'b0; cyc(h); end
    end
    compared += 2;
    if (fd_n_cnt - fdn0 != ((nclk >= 8) ? 1 : 0)) begin
      mismatched++; $display("FAIL nes_fd_count: got %0d want %0d", fd_n_cnt - fdn0, (nclk >= 8) ? 1 : 0);
    end
    if (fd_s_cnt - fds0 != ((nclk >= 16) ? 1 : 0)) begin
      mismatched++; $display("FAIL snes_fd_count: got %0d want %0d", fd_s_cnt - fds0, (nclk >= 16) ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    compared += 6;
    if (n_data !== 1'b1) begin mismatched++; $display("FAIL reset_nes_data: got %b want 1", n_data); end
    if (n_busy !== 1'b0) begin mismatched++; $display("FAIL reset_nes_busy: got %b want 0", n_busy); end
    if (n_fd !== 1'b0) begin mismatched++; $display("FAIL reset_nes_fd: got %b want 0", n_fd); end
    if (s_data !== 1'b1) begin mismatched++; $display("FAIL reset_snes_data: got %b want 1", s_data); end
    if (s_busy !== 1'b0) begin mismatched++; $display("FAIL reset_snes_busy: got %b want 0", s_busy); end
    if (s_fd !== 1'b0) begin mismatched++; $display("FAIL reset_snes_fd: got %b want 0", s_fd); end
    rst_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_nes_a_start();
    logic [7:0] want;
    logic [7:0] got;
    int fdn0;
    fdn0 = fd_n_cnt;
    want = 8'b1111_0110;
    buttons = 12'h009;
    nes_latch = 1'b1; cyc(6);
    nes_latch = 1'b0; cyc(6);
    for (int k = 0; k < 8; k++) begin
      got[k] = n_data;
      nes_clk = 1'b1; cyc(6);
      nes_clk = 1'b0; cyc(6);
    end
    compared += 3;
    if (got !== want) begin mismatched++; $display("FAIL nes_seq_009: got %b want %b", got, want); end
    if (n_data !== 1'b1) begin mismatched++; $display("FAIL nes_after8: got %b want 1", n_data); end
    if (fd_n_cnt - fdn0 != 1) begin mismatched++; $display("FAIL nes_fd_once: got %0d want 1", fd_n_cnt - fdn0); end
  endtask

  task automatic test_snes_all_pressed();
    run_frame(12'hFFF, 0, 17, 6);
  endtask

  task automatic test_snapshot_hold();
    buttons = 12'h000;
    nes_latch = 1'b1; cyc(6);
    nes_latch = 1'b0; cyc(6);
    buttons = 12'h001;
    for (int k = 0; k < 8; k++) begin
      compared++;
      if (n_data !== 1'b1) begin mismatched++; $display("FAIL snapshot_bit%0d: got %b want 1", k, n_data); end
      nes_clk = 1'b1; cyc(6);
      nes_clk = 1'b0; cyc(6);
    end
  endtask

  task automatic test_clock_during_latch();
    run_frame(12'h5A5, 5, 16, 5);
  endtask

  task automatic test_restart_mid_frame();
    run_frame(12'h0F3, 0, 3, 6);
    run_frame(12'hA3C, 0, 16, 6);
  endtask

  task automatic test_timeout();
    logic [11:0] b;
    int fdn0;
    fdn0 = fd_n_cnt;
    b = 12'($urandom);
    buttons = b;
    nes_latch = 1'b1; cyc(6);
    nes_latch = 1'b0; cyc(6);
    nes_clk = 1'b1; cyc(6);
    nes_clk = 1'b0; cyc(6);
    nes_clk = 1'b1; cyc(6);
    nes_clk = 1'b0; cyc(92);
    compared += 3;
    if (n_busy !== 1'b1) begin mismatched++; $display("FAIL tmo_busy_before: got %b want 1", n_busy); end
    if (n_data !== exp_bit(b, 8, 2)) begin mismatched++; $display("FAIL tmo_data_before: got %b want %b", n_data, exp_bit(b, 8, 2)); end
    if (s_busy !== 1'b1) begin mismatched++; $display("FAIL tmo_snes_busy_before: got %b want 1", s_busy); end
    cyc(10);
    compared += 4;
    if (n_busy !== 1'b0) begin mismatched++; $display("FAIL tmo_busy_after: got %b want 0", n_busy); end
    if (n_data !== 1'b1) begin mismatched++; $display("FAIL tmo_data_after: got %b want 1", n_data); end
    if (fd_n_cnt != fdn0) begin mismatched++; $display("FAIL tmo_no_fd: got %0d want %0d", fd_n_cnt, fdn0); end
    if (s_busy !== 1'b1) begin mismatched++; $display("FAIL tmo_snes_still_busy: got %b want 1", s_busy); end
  endtask

  task automatic test_async_reset();
    buttons = 12'hFFF;
    nes_latch = 1'b1; cyc(6);
    nes_latch = 1'b0; cyc(6);
    for (int i = 0; i < 3; i++) begin
      nes_clk = 1'b1; cyc(6);
      nes_clk = 1'b0; cyc(6);
    end
    compared++;
    if (s_data !== 1'b0) begin mismatched++; $display("FAIL arst_pre_data: got %b want 0", s_data); end
    #2;
    rst_n = 1'b0;
    #1;
    compared += 4;
    if (n_data !== 1'b1 || n_busy !== 1'b0) begin mismatched++; $display("FAIL arst_nes: data=%b busy=%b want 1/0", n_data, n_busy); end
    if (s_data !== 1'b1) begin mismatched++; $display("FAIL arst_snes_data: got %b want 1", s_data); end
    if (s_busy !== 1'b0) begin mismatched++; $display("FAIL arst_snes_busy: got %b want 0", s_busy); end
    if (s_fd !== 1'b0 || n_fd !== 1'b0) begin mismatched++; $display("FAIL arst_fd: nes=%b snes=%b want 0/0", n_fd, s_fd); end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    for (int i = 0; i < 3; i++) begin
      nes_clk = 1'b1; cyc(6);
      nes_clk = 1'b0; cyc(6);
    end
    compared += 2;
    if (s_busy !== 1'b0 || s_data !== 1'b1) begin mismatched++; $display("FAIL arst_no_latch: busy=%b data=%b want 0/1", s_busy, s_data); end
    if (n_busy !== 1'b0 || n_data !== 1'b1) begin mismatched++; $display("FAIL arst_nes_no_latch: busy=%b data=%b want 0/1", n_busy, n_data); end
    run_frame(12'h3C5, 0, 16, 6);
  endtask

  task automatic test_random();
    for (int it = 0; it < 14; it++) begin
      run_frame(12'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(3, 17)),
                int'($urandom_range(5, 8)));
    end
  endtask

  initial begin
    test_reset();
    test_nes_a_start();
    test_snes_all_pressed();
    test_snapshot_hold();
    test_clock_during_latch();
    test_restart_mid_frame();
    test_timeout();
    test_async_reset();
    test_random();
    cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
